// File: rtl/pc_sequencer.sv
// Fetch-stage program-counter sequencer: owns the PC register and picks the next PC
// (increment, absolute LUT branch, hold, halt). It also brackets each run with a start/done handshake.
module pc_sequencer #(
  parameter int D          = 12,
  parameter int START_ADDR = 0,
  parameter int CNT_W      = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             start,
  input  logic             stall,
  input  logic             halt_req,
  input  logic             branch_en,
  input  logic             branch_taken,
  input  logic [4:0]       branch_sel,
  output logic [4:0]       lut_addr,
  input  logic [D-1:0]     lut_target,
  output logic [D-1:0]     pc,
  output logic             running,
  output logic             done,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [D-1:0] START_PC = D'(START_ADDR);

  state_t           state_q, state_d;
  logic [D-1:0]     pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             running_q, done_q;

  // Handshake: start is a level. It is accepted on any rising edge where it is high in
  // IDLE or HALT (RUN ignores it). done then rises when a halt is accepted and stays high
  // until the next accepted start. There is no back-pressure on either side.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, HALT: begin
        if (start) begin
          state_d = RUN;
          pc_d    = START_PC;
          cnt_d   = '0;
        end
      end
      RUN: begin
        // Every RUN cycle counts, including stalls and the halt-accept cycle.
        cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
        if (stall) begin
          pc_d = pc_q;
        end else if (halt_req) begin
          state_d = HALT;
        end else if (branch_en && branch_taken) begin
          pc_d = lut_target;
        end else begin
          pc_d = pc_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      running_q <= (state_d == RUN);
      done_q    <= (state_d == HALT);
    end
  end

  assign lut_addr  = branch_sel;
  assign pc        = pc_q;
  assign running   = running_q;
  assign done      = done_q;
  assign cycle_cnt = cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a table of per-cycle vectors with scoreboarded expectations, plus
// hand sequences for mid-run asynchronous reset and run-counter saturation (narrow instance).
module tb_pc_sequencer;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        start, stall, halt_req, branch_en, branch_taken;
  logic [4:0]  branch_sel;
  logic [4:0]  lut_addr, lut_addr_s;
  logic [11:0] lut_target, lut_target_s;
  logic [11:0] pc, pc_s;
  logic        running, done, running_s, done_s;
  logic [15:0] cycle_cnt;
  logic [3:0]  cycle_cnt_s;
  logic [1:0]  dbg_state, dbg_state_s;

  logic [11:0] lut_mem [32];
  logic [29:0] exp_q[$];
  int          total = 0;
  int          bad   = 0;

  typedef struct {
    logic        st, sl, hr, be, bt;
    logic [4:0]  sel;
    logic [11:0] pc;
    logic        run, dn;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];

  always #5 Clk = ~Clk;

  assign lut_target   = lut_mem[lut_addr];
  assign lut_target_s = lut_mem[lut_addr_s];

  pc_sequencer #(.D(12), .START_ADDR(0), .CNT_W(16)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .stall(stall), .halt_req(halt_req),
    .branch_en(branch_en), .branch_taken(branch_taken), .branch_sel(branch_sel),
    .lut_addr(lut_addr), .lut_target(lut_target), .pc(pc), .running(running),
    .done(done), .cycle_cnt(cycle_cnt), .dbg_state(dbg_state)
  );

  pc_sequencer #(.D(12), .START_ADDR(0), .CNT_W(4)) dut_s (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .stall(stall), .halt_req(halt_req),
    .branch_en(branch_en), .branch_taken(branch_taken), .branch_sel(branch_sel),
    .lut_addr(lut_addr_s), .lut_target(lut_target_s), .pc(pc_s), .running(running_s),
    .done(done_s), .cycle_cnt(cycle_cnt_s), .dbg_state(dbg_state_s)
  );

  function automatic vec_t mk(input logic st, sl, hr, be, bt, input logic [4:0] sel,
                              input logic [11:0] epc, input logic erun, edn,
                              input logic [15:0] ecnt);
    vec_t v;
    v.st = st; v.sl = sl; v.hr = hr; v.be = be; v.bt = bt; v.sel = sel;
    v.pc = epc; v.run = erun; v.dn = edn; v.cnt = ecnt;
    return v;
  endfunction

  task automatic add(input logic st, sl, hr, be, bt, input logic [4:0] sel,
                     input logic [11:0] epc, input logic erun, edn, input logic [15:0] ecnt);
    vecs.push_back(mk(st, sl, hr, be, bt, sel, epc, erun, edn, ecnt));
  endtask

  task automatic step(input vec_t v, input string name);
    logic [29:0] exp_v, act_v;
    @(negedge Clk);
    start = v.st; stall = v.sl; halt_req = v.hr;
    branch_en = v.be; branch_taken = v.bt; branch_sel = v.sel;
    exp_q.push_back({v.run, v.dn, v.pc, v.cnt});
    #1;
    total++;
    if (lut_addr !== v.sel) begin
      bad++;
      $display("FAIL %s lut_addr: got %0d want %0d", name, lut_addr, v.sel);
    end
    @(posedge Clk);
    #1;
    exp_v = exp_q.pop_front();
    act_v = {running, done, pc, cycle_cnt};
    total++;
    if (act_v !== exp_v) begin
      bad++;
      $display("FAIL %s outputs: got run=%0d done=%0d pc=%0d cnt=%0d want run=%0d done=%0d pc=%0d cnt=%0d",
               name, act_v[29], act_v[28], act_v[27:16], act_v[15:0],
               exp_v[29], exp_v[28], exp_v[27:16], exp_v[15:0]);
    end
  endtask

  task automatic check_reset(input string name);
    total++;
    if ({running, done, pc, cycle_cnt, dbg_state} !== 32'd0) begin
      bad++;
      $display("FAIL %s: got run=%0d done=%0d pc=%0d cnt=%0d state=%0d want all 0",
               name, running, done, pc, cycle_cnt, dbg_state);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) lut_mem[i] = 12'd0;
    lut_mem[0] = 12'd21;
    lut_mem[1] = 12'd100;
    lut_mem[2] = 12'd4095;
    lut_mem[3] = 12'd10;
    lut_mem[4] = 12'd29;

    // Per-cycle vectors: st sl hr be bt sel | pc run done cnt after the edge
    add(0,0,0,0,0,5'd0,  12'd0,    0,0,16'd0);
    add(1,0,0,0,0,5'd0,  12'd0,    1,0,16'd0);
    for (int k = 1; k <= 7; k++) add(0,0,0,0,0,5'd1, 12'(k), 1,0,16'(k));
    add(0,0,0,1,1,5'd0,  12'd21,   1,0,16'd8);
    add(0,0,0,1,0,5'd0,  12'd22,   1,0,16'd9);
    add(0,0,0,1,1,5'd2,  12'd4095, 1,0,16'd10);
    add(0,0,0,0,0,5'd0,  12'd0,    1,0,16'd11);
    add(0,0,0,1,1,5'd3,  12'd10,   1,0,16'd12);
    add(0,1,0,0,0,5'd0,  12'd10,   1,0,16'd13);
    add(0,1,0,1,1,5'd4,  12'd10,   1,0,16'd14);
    add(0,1,1,0,0,5'd0,  12'd10,   1,0,16'd15);
    add(0,0,0,1,1,5'd31, 12'd0,    1,0,16'd16);
    add(0,0,0,1,1,5'd4,  12'd29,   1,0,16'd17);
    add(0,0,0,0,0,5'd0,  12'd30,   1,0,16'd18);
    add(1,0,1,0,0,5'd0,  12'd30,   0,1,16'd19);
    add(0,0,0,0,0,5'd0,  12'd30,   0,1,16'd19);
    add(0,0,0,1,1,5'd0,  12'd30,   0,1,16'd19);
    add(1,0,0,0,0,5'd0,  12'd0,    1,0,16'd0);
    add(1,0,0,0,0,5'd0,  12'd1,    1,0,16'd1);
    for (int k = 2; k <= 12; k++) add(0,0,0,0,0,5'd7, 12'(k), 1,0,16'(k));

    Reset_n = 1'b0;
    start = 0; stall = 0; halt_req = 0; branch_en = 0; branch_taken = 0; branch_sel = 5'd0;
    repeat (2) @(posedge Clk);
    #1;
    check_reset("reset_state");
    @(negedge Clk);
    Reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("row%0d", i));

    // Asynchronous reset in the middle of a run at pc=12, well away from any edge.
    #2;
    Reset_n = 1'b0;
    #1;
    check_reset("async_reset_mid_run");
    @(negedge Clk);
    Reset_n = 1'b1;

    step(mk(0,0,0,0,0,5'd3, 12'd0, 0,0,16'd0), "idle_after_reset");
    step(mk(1,0,0,0,0,5'd3, 12'd0, 1,0,16'd0), "sat_start");
    for (int k = 1; k <= 20; k++) begin
      step(mk(0,0,0,0,0,5'd9, 12'(k), 1,0,16'(k)), $sformatf("sat_run%0d", k));
      if (k == 10) begin
        total++;
        if (cycle_cnt_s !== 4'd10) begin
          bad++;
          $display("FAIL narrow_cnt_10: got %0d want 10", cycle_cnt_s);
        end
      end
    end
    total++;
    if (cycle_cnt_s !== 4'd15) begin
      bad++;
      $display("FAIL narrow_cnt_saturate: got %0d want 15", cycle_cnt_s);
    end
    total++;
    if (pc_s !== 12'd20 || running_s !== 1'b1) begin
      bad++;
      $display("FAIL narrow_pc: got pc=%0d run=%0d want pc=20 run=1", pc_s, running_s);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
